ipgu_addr_gen: RTL and testbench
================================

Name: ipgu_addr_gen

Overview:
- Raster address generator feeding the IPGU control unit and its source/destination RAM pair.
- Walks one pyramid level as a grid of non-overlapping WIN_SIZE x WIN_SIZE windows, row-major across windows and raster order within each window.
- Each incX pulse from the control unit advances by one pixel.
- Outputs the current pixel coordinate, the current window bounds, and the packed RAM address.

Parameters:
RAM_ADDR_WIDTH, 18, RAM address width; each coordinate is RAM_ADDR_WIDTH/2 bits (CW = 9).
WIN_SIZE, 20, window edge length in pixels.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
start  input  1  restart the scan at window (0,0) and latch numWindows
incX  input  1  advance one pixel
numWindows  input  4  windows per row/column for this level (grid is numWindows x numWindows)
addrX  output  CW  current pixel column
addrY  output  CW  current pixel row
addrXBegin  output  CW  current window left column
addrXEnd  output  CW  current window right column (addrXBegin+WIN_SIZE-1)
addrYBegin  output  CW  current window top row
addrYEnd  output  CW  current window bottom row (addrYBegin+WIN_SIZE-1)
ramAddr  output  RAM_ADDR_WIDTH  {addrY, addrX}
windowIdx  output  8  windows completed in the current level (0..numWindows^2-1)
lastWindow  output  1  current window is the final window of the grid
frameDone  output  1  one-cycle pulse when the last pixel of the last window is consumed
busy  output  1  a level scan is in progress

Behaviour:
- Reset state:
  - All coordinates and begin values = 0; addrXEnd = addrYEnd = WIN_SIZE-1.
  - windowIdx = 0, lastWindow = 0, frameDone = 0, busy = 0, latched numWindows (nwL) = 0.
- Register style:
  - Registered: addrX, addrY, addrXBegin, addrYBegin, windowIdx, nwL, busy, frameDone.
  - Combinational: addrXEnd, addrYEnd, ramAddr, lastWindow.
  - No extra latency: ramAddr reflects the registered coordinate in the same cycle.
- start (has priority over incX in the same cycle):
  - Next cycle: all coordinates = 0, windowIdx = 0, nwL = numWindows.
  - busy = 1 if numWindows != 0, otherwise busy = 0.
  - start asserted mid-scan aborts the scan and restarts; no frameDone pulse is produced.
- incX is ignored when busy = 0. Otherwise each cycle with incX applies the first matching rule:
  - addrX != addrXEnd: addrX += 1.
  - addrX == addrXEnd and addrY != addrYEnd: addrX = addrXBegin, addrY += 1.
  - Window end, not last window, addrXBegin+WIN_SIZE != nwL*WIN_SIZE: addrXBegin += WIN_SIZE; addrX = new addrXBegin; addrY = addrYBegin; windowIdx += 1.
  - Window end, last column of the grid, not last row: addrXBegin = 0; addrYBegin += WIN_SIZE; addrX = 0; addrY = new addrYBegin; windowIdx += 1.
  - Window end, last window: all coordinates = 0, windowIdx = 0, busy = 0, frameDone = 1 for exactly one cycle.
- lastWindow = busy && addrXBegin+WIN_SIZE == nwL*WIN_SIZE && addrYBegin+WIN_SIZE == nwL*WIN_SIZE.
- Width rules:
  - Products and comparisons are computed at CW+1 bits, so nwL = 15 gives 300 with no overflow.
  - nwL*WIN_SIZE must not exceed 2^CW; numWindows above that is out of range and not required to work.
- numWindows changes while busy have no effect until the next start.
- frameDone and start in the same cycle: start is taken; frameDone still pulses (it is registered from the previous cycle's event).
- Reset asserted mid-scan returns all outputs to reset values immediately; no pulse is generated.

Test Plan:
- Reset:
  - Stimulus: assert rst_n low at any point.
  - Required: addrX = addrY = 0, addrXEnd = addrYEnd = 19, ramAddr = 0, busy = 0, frameDone = 0.
- Single-window scan:
  - Stimulus: start with numWindows = 1, then 400 incX pulses.
  - Required: pulse 20 gives (X=0, Y=1), ramAddr = 0x200; pulse 399 gives (19,19) with lastWindow = 1.
  - Required: pulse 400 gives frameDone = 1 for one cycle, then busy = 0, coordinates = 0.
- Window stepping:
  - Stimulus: start with numWindows = 3.
  - Required: after 400 incX, addrXBegin = 20, addrX = 20, windowIdx = 1.
  - Required: after 1200 incX, addrXBegin = 0, addrYBegin = 20, addrY = 20, windowIdx = 3.
  - Required: frameDone on pulse 3600.
- Full level and idle behaviour:
  - Stimulus: start with numWindows = 15, 90000 incX.
  - Required: lastWindow rises at windowIdx = 224 with addrXBegin = addrYBegin = 280; frameDone pulses once.
  - Required: further incX with busy = 0 changes nothing.
- Priority and latching:
  - Stimulus: start and incX in the same cycle. Required: coordinates = 0 (start wins).
  - Stimulus: change numWindows from 3 to 1 mid-scan. Required: grid stays 3x3.
  - Stimulus: start with numWindows = 0. Required: busy stays 0 and incX is ignored.
- Abort:
  - Stimulus: after 500 incX at numWindows = 3, assert start.
  - Required: no frameDone, windowIdx = 0, scan restarts at (0,0).

Source files
------------

// File: rtl/ipgu_addr_gen.sv
// Raster address generator for the IPGU. Walks a numWindows x numWindows grid of
// WIN_SIZE x WIN_SIZE windows, row-major across windows and raster order inside each
// window, advancing one pixel per incX. Coordinates and window origins are registered;
// window ends, the packed RAM address and lastWindow are derived combinationally.
module ipgu_addr_gen #(
  parameter int unsigned RAM_ADDR_WIDTH = 18,
  parameter int unsigned WIN_SIZE       = 20
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          incX,
  input  logic [3:0]                    numWindows,
  output logic [RAM_ADDR_WIDTH/2-1:0]   addrX,
  output logic [RAM_ADDR_WIDTH/2-1:0]   addrY,
  output logic [RAM_ADDR_WIDTH/2-1:0]   addrXBegin,
  output logic [RAM_ADDR_WIDTH/2-1:0]   addrXEnd,
  output logic [RAM_ADDR_WIDTH/2-1:0]   addrYBegin,
  output logic [RAM_ADDR_WIDTH/2-1:0]   addrYEnd,
  output logic [RAM_ADDR_WIDTH-1:0]     ramAddr,
  output logic [7:0]                    windowIdx,
  output logic                          lastWindow,
  output logic                          frameDone,
  output logic                          busy
);

  localparam int unsigned CW = RAM_ADDR_WIDTH / 2;
  // Grid arithmetic is one bit wider than a coordinate so a full 15-window row (300)
  // or a span equal to 2^CW compares without wrapping.
  localparam logic [CW:0]   WIN_EXT = (CW+1)'(WIN_SIZE);
  localparam logic [CW-1:0] WIN_M1  = CW'(WIN_SIZE - 1);

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] xb_q, xb_d, yb_q, yb_d;
  logic [7:0]    idx_q, idx_d;
  logic [3:0]    nw_q, nw_d;
  logic          busy_q, busy_d;
  logic          fd_q, fd_d;

  logic [CW-1:0] x_end, y_end;
  logic [CW:0]   span, xb_next, yb_next;
  logic          col_last, row_last;

  assign x_end    = xb_q + WIN_M1;
  assign y_end    = yb_q + WIN_M1;
  assign span     = (CW+1)'(nw_q) * WIN_EXT;
  assign xb_next  = {1'b0, xb_q} + WIN_EXT;
  assign yb_next  = {1'b0, yb_q} + WIN_EXT;
  assign col_last = (xb_next == span);
  assign row_last = (yb_next == span);

  // Next-state: start restarts the level, otherwise incX steps pixel/row/window/frame.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    xb_d   = xb_q;
    yb_d   = yb_q;
    idx_d  = idx_q;
    nw_d   = nw_q;
    busy_d = busy_q;
    fd_d   = 1'b0;
    if (start) begin
      x_d    = '0;
      y_d    = '0;
      xb_d   = '0;
      yb_d   = '0;
      idx_d  = '0;
      nw_d   = numWindows;
      busy_d = (numWindows != 4'd0);
    end else if (incX && busy_q) begin
      if (x_q != x_end) begin
        x_d = x_q + 1'b1;
      end else if (y_q != y_end) begin
        x_d = xb_q;
        y_d = y_q + 1'b1;
      end else if (!col_last) begin
        xb_d  = xb_next[CW-1:0];
        x_d   = xb_next[CW-1:0];
        y_d   = yb_q;
        idx_d = idx_q + 8'd1;
      end else if (!row_last) begin
        xb_d  = '0;
        yb_d  = yb_next[CW-1:0];
        x_d   = '0;
        y_d   = yb_next[CW-1:0];
        idx_d = idx_q + 8'd1;
      end else begin
        x_d    = '0;
        y_d    = '0;
        xb_d   = '0;
        yb_d   = '0;
        idx_d  = '0;
        busy_d = 1'b0;
        fd_d   = 1'b1;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      xb_q   <= '0;
      yb_q   <= '0;
      idx_q  <= '0;
      nw_q   <= '0;
      busy_q <= 1'b0;
      fd_q   <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      xb_q   <= xb_d;
      yb_q   <= yb_d;
      idx_q  <= idx_d;
      nw_q   <= nw_d;
      busy_q <= busy_d;
      fd_q   <= fd_d;
    end
  end

  assign addrX      = x_q;
  assign addrY      = y_q;
  assign addrXBegin = xb_q;
  assign addrYBegin = yb_q;
  assign addrXEnd   = x_end;
  assign addrYEnd   = y_end;
  assign ramAddr    = {y_q, x_q};
  assign windowIdx  = idx_q;
  assign lastWindow = busy_q & col_last & row_last;
  assign frameDone  = fd_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_ipgu_addr_gen.sv
// Bench for ipgu_addr_gen: a directed vector table, hand-written scans of the test-plan
// scenarios, and a randomized phase. Every cycle is also compared against a model that
// derives the full output set from the pixel count since start.
module tb_ipgu_addr_gen;

  localparam int WIN  = 20;
  localparam int AREA = WIN * WIN;

  logic       clk, rst_n, start, incX;
  logic [3:0] numWindows;
  logic [8:0] addrX, addrY, addrXBegin, addrXEnd, addrYBegin, addrYEnd;
  logic [17:0] ramAddr;
  logic [7:0] windowIdx;
  logic       lastWindow, frameDone, busy;

  ipgu_addr_gen #(.RAM_ADDR_WIDTH(18), .WIN_SIZE(WIN)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .incX(incX), .numWindows(numWindows),
    .addrX(addrX), .addrY(addrY), .addrXBegin(addrXBegin), .addrXEnd(addrXEnd),
    .addrYBegin(addrYBegin), .addrYEnd(addrYEnd), .ramAddr(ramAddr),
    .windowIdx(windowIdx), .lastWindow(lastWindow), .frameDone(frameDone), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int fd_count = 0;

  // Reference model: pixels consumed since start, latched grid size, busy flag.
  int m_n = 0, m_nw = 0;
  bit m_busy = 0, m_fd = 0;

  typedef struct {
    bit s; bit inc; int nw; int ex; int ey; bit eb;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(string name, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic check_model(string tag);
    int w, p, wx, wy, xb, yb, x, y, idx, ram;
    bit last;
    if (m_busy) begin
      w = m_n / AREA; p = m_n % AREA;
      xb = (w % m_nw) * WIN; yb = (w / m_nw) * WIN;
      x = xb + p % WIN; y = yb + p / WIN;
      idx = w; last = (w == m_nw * m_nw - 1);
    end else begin
      xb = 0; yb = 0; x = 0; y = 0; idx = 0; last = 0;
    end
    ram = y * 512 + x;
    total++;
    if (addrX != x || addrY != y || addrXBegin != xb || addrYBegin != yb ||
        addrXEnd != xb + WIN - 1 || addrYEnd != yb + WIN - 1 || ramAddr != ram ||
        windowIdx != idx || lastWindow != last || frameDone != m_fd || busy != m_busy) begin
      bad++;
      $display({"FAIL model[%s] cyc=%0d got x=%0d y=%0d xb=%0d xe=%0d yb=%0d ye=%0d ram=%0h",
                " idx=%0d last=%0b fd=%0b busy=%0b want x=%0d y=%0d xb=%0d yb=%0d ram=%0h",
                " idx=%0d last=%0b fd=%0b busy=%0b"},
               tag, cyc, addrX, addrY, addrXBegin, addrXEnd, addrYBegin, addrYEnd, ramAddr,
               windowIdx, lastWindow, frameDone, busy, x, y, xb, yb, ram, idx, last, m_fd,
               m_busy);
    end
  endtask

  // Apply one cycle of inputs (called at posedge+1), then update model and compare.
  task automatic tick(bit s, bit inc, int nw, string tag = "tick");
    start = s; incX = inc; numWindows = 4'(nw);
    @(posedge clk); #1;
    cyc++;
    m_fd = 0;
    if (s) begin
      m_n = 0; m_nw = nw; m_busy = (nw != 0);
    end else if (inc && m_busy) begin
      m_n++;
      if (m_n == m_nw * m_nw * AREA) begin
        m_n = 0; m_busy = 0; m_fd = 1;
      end
    end
    if (frameDone) fd_count++;
    check_model(tag);
  endtask

  task automatic run_inc(int k, int nw);
    for (int i = 0; i < k; i++) tick(1'b0, 1'b1, nw, "run");
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; incX = 1'b0; numWindows = 4'd0;
    @(posedge clk); @(posedge clk); #1;
    // Reset state
    chk("rst_x", addrX, 0);
    chk("rst_y", addrY, 0);
    chk("rst_xend", addrXEnd, 19);
    chk("rst_yend", addrYEnd, 19);
    chk("rst_ram", ramAddr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fd", frameDone, 0);
    rst_n = 1'b1;

    // Directed vector table
    vecs[0]  = '{1, 0, 2, 0, 0, 1};
    vecs[1]  = '{0, 1, 2, 1, 0, 1};
    vecs[2]  = '{0, 1, 2, 2, 0, 1};
    vecs[3]  = '{1, 1, 2, 0, 0, 1};
    vecs[4]  = '{0, 1, 2, 1, 0, 1};
    vecs[5]  = '{0, 0, 2, 1, 0, 1};
    vecs[6]  = '{1, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 1, 0, 0, 0, 0};
    vecs[8]  = '{0, 1, 5, 0, 0, 0};
    vecs[9]  = '{1, 1, 1, 0, 0, 1};
    vecs[10] = '{0, 1, 1, 1, 0, 1};
    vecs[11] = '{0, 1, 1, 2, 0, 1};
    for (int i = 0; i < 12; i++) begin
      tick(vecs[i].s, vecs[i].inc, vecs[i].nw, "vec");
      chk($sformatf("vec%0d_x", i), addrX, vecs[i].ex);
      chk($sformatf("vec%0d_y", i), addrY, vecs[i].ey);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].eb);
    end

    // Single-window scan
    tick(1'b1, 1'b0, 1, "single");
    run_inc(20, 1);
    chk("single_p20_x", addrX, 0);
    chk("single_p20_y", addrY, 1);
    chk("single_p20_ram", ramAddr, 'h200);
    run_inc(379, 1);
    chk("single_p399_x", addrX, 19);
    chk("single_p399_y", addrY, 19);
    chk("single_p399_last", lastWindow, 1);
    chk("single_p399_fd", frameDone, 0);
    run_inc(1, 1);
    chk("single_p400_fd", frameDone, 1);
    tick(1'b0, 1'b0, 1, "single");
    chk("single_after_fd", frameDone, 0);
    chk("single_after_busy", busy, 0);
    chk("single_after_x", addrX, 0);

    // 3x3 stepping, numWindows changed mid-scan must not matter
    tick(1'b1, 1'b0, 3, "grid3");
    run_inc(100, 3);
    run_inc(300, 1);
    chk("g3_p400_xb", addrXBegin, 20);
    chk("g3_p400_x", addrX, 20);
    chk("g3_p400_idx", windowIdx, 1);
    run_inc(800, 1);
    chk("g3_p1200_xb", addrXBegin, 0);
    chk("g3_p1200_yb", addrYBegin, 20);
    chk("g3_p1200_y", addrY, 20);
    chk("g3_p1200_idx", windowIdx, 3);
    run_inc(2399, 3);
    chk("g3_p3599_fd", frameDone, 0);
    chk("g3_p3599_last", lastWindow, 1);
    run_inc(1, 3);
    chk("g3_p3600_fd", frameDone, 1);

    // Abort mid-scan with start
    tick(1'b1, 1'b0, 3, "abort");
    run_inc(500, 3);
    tick(1'b1, 1'b0, 3, "abort");
    chk("abort_fd", frameDone, 0);
    chk("abort_idx", windowIdx, 0);
    chk("abort_x", addrX, 0);
    chk("abort_y", addrY, 0);
    chk("abort_busy", busy, 1);
    tick(1'b0, 1'b0, 3, "abort");
    chk("abort_fd2", frameDone, 0);
    run_inc(5, 3);
    chk("abort_resume_x", addrX, 5);

    // Asynchronous reset mid-scan
    rst_n = 1'b0;
    #1;
    chk("arst_x", addrX, 0);
    chk("arst_busy", busy, 0);
    chk("arst_xend", addrXEnd, 19);
    chk("arst_idx", windowIdx, 0);
    m_n = 0; m_nw = 0; m_busy = 0; m_fd = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    tick(1'b0, 1'b1, 3, "arst");
    chk("arst_fd", frameDone, 0);

    // Full 15x15 level
    tick(1'b1, 1'b0, 15, "grid15");
    fd_count = 0;
    run_inc(89599, 15);
    chk("g15_pre_last", lastWindow, 0);
    chk("g15_pre_idx", windowIdx, 223);
    run_inc(1, 15);
    chk("g15_last", lastWindow, 1);
    chk("g15_last_idx", windowIdx, 224);
    chk("g15_last_xb", addrXBegin, 280);
    chk("g15_last_yb", addrYBegin, 280);
    run_inc(400, 15);
    chk("g15_fd", frameDone, 1);
    run_inc(10, 15);
    chk("g15_fd_count", fd_count, 1);
    chk("idle_busy", busy, 0);
    chk("idle_x", addrX, 0);
    chk("idle_y", addrY, 0);

    // Randomized phase
    for (int i = 0; i < 600; i++) begin
      bit s, inc;
      int nw;
      s   = ($urandom_range(0, 99) == 0) || (!m_busy && $urandom_range(0, 3) == 0);
      inc = ($urandom_range(0, 9) != 0);
      nw  = $urandom_range(0, 2);
      tick(s, inc, nw, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
